// File: rtl/ball_motion_scheduler_if.sv
// Position-update handshake between the motion scheduler and the
// shared datapath: one ball index per req/ack transaction.
interface ball_motion_scheduler_if #(
    parameter int IDX_W = 2
);
    logic             upd_req;
    logic [IDX_W-1:0] upd_sel;
    logic             upd_ack;

    modport master (
        output upd_req,
        output upd_sel,
        input  upd_ack
    );

    modport slave (
        input  upd_req,
        input  upd_sel,
        output upd_ack
    );
endinterface

// File: rtl/ball_motion_scheduler.sv
// Per-frame motion sequencer: cue shot gating, round-robin position-update
// scan of every ball, and table-at-rest detection with a long rest hold.
module ball_motion_scheduler #(
    parameter int NUM_BALLS   = 4,
    parameter int IDX_W       = 2,
    parameter int REST_FRAMES = 3,
    parameter int HOLD_CYCLES = 64,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame_tick,
    input  logic                    cue_fire,
    input  logic [NUM_BALLS-1:0]    done_fric,
    ball_motion_scheduler_if.master upd,
    output logic                    cue_hit,
    output logic                    done_fric_all,
    output logic                    shot_ready,
    output logic                    overrun,
    output logic                    ack_err
);
    localparam int TMO_W  = $clog2(ACK_TIMEOUT + 1);
    localparam int REST_W = $clog2(REST_FRAMES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_BALLS - 1);
    localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(ACK_TIMEOUT);
    localparam logic [REST_W-1:0] REST_MAX  = REST_W'(REST_FRAMES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_READY,
        S_SHOT,
        S_WAIT,
        S_SCAN,
        S_CHECK,
        S_HOLD
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d, tmo_nxt;
    logic [REST_W-1:0] rest_q, rest_d, rest_nxt;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              upd_req_q, upd_req_d;
    logic              cue_hit_q, cue_hit_d;
    logic              dfa_q, dfa_d;
    logic              shot_ready_q, shot_ready_d;
    logic              overrun_q, overrun_d;
    logic              ack_err_q, ack_err_d;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tmo_d     = tmo_q;
        rest_d    = rest_q;
        hold_d    = hold_q;
        upd_req_d = 1'b0;
        cue_hit_d = 1'b0;
        dfa_d     = 1'b0;
        ack_err_d = ack_err_q;
        overrun_d = overrun_q
                  | (frame_tick & ((state_q == S_SCAN) | (state_q == S_CHECK)));
        tmo_nxt   = tmo_q + 1'b1;
        rest_nxt  = (rest_q == REST_MAX) ? rest_q : rest_q + 1'b1;

        unique case (state_q)
            S_READY: begin
                if (cue_fire) begin
                    state_d   = S_SHOT;
                    cue_hit_d = 1'b1;
                end
            end
            S_SHOT: begin
                state_d = S_WAIT;
                rest_d  = '0;
            end
            S_WAIT: begin
                if (frame_tick) begin
                    state_d   = S_SCAN;
                    idx_d     = '0;
                    tmo_d     = '0;
                    upd_req_d = 1'b1;
                end
            end
            S_SCAN: begin
                // req low here is the mandatory gap before the next ball
                if (!upd_req_q) begin
                    upd_req_d = 1'b1;
                    tmo_d     = '0;
                end else if (upd.upd_ack || (tmo_nxt == TMO_MAX)) begin
                    ack_err_d = ack_err_q | ~upd.upd_ack;
                    tmo_d     = upd.upd_ack ? '0 : TMO_MAX;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_CHECK;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    upd_req_d = 1'b1;
                    tmo_d     = tmo_nxt;
                end
            end
            S_CHECK: begin
                if (&done_fric) begin
                    rest_d = rest_nxt;
                    if (rest_nxt == REST_MAX) begin
                        state_d = S_HOLD;
                        hold_d  = '0;
                        dfa_d   = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    rest_d  = '0;
                    state_d = S_WAIT;
                end
            end
            S_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = S_READY;
                end else begin
                    hold_d = hold_q + 1'b1;
                    dfa_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_READY;
            end
        endcase

        shot_ready_d = (state_d == S_READY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_READY;
            idx_q        <= '0;
            tmo_q        <= '0;
            rest_q       <= '0;
            hold_q       <= '0;
            upd_req_q    <= 1'b0;
            cue_hit_q    <= 1'b0;
            dfa_q        <= 1'b0;
            shot_ready_q <= 1'b1;
            overrun_q    <= 1'b0;
            ack_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            tmo_q        <= tmo_d;
            rest_q       <= rest_d;
            hold_q       <= hold_d;
            upd_req_q    <= upd_req_d;
            cue_hit_q    <= cue_hit_d;
            dfa_q        <= dfa_d;
            shot_ready_q <= shot_ready_d;
            overrun_q    <= overrun_d;
            ack_err_q    <= ack_err_d;
        end
    end

    assign upd.upd_req   = upd_req_q;
    assign upd.upd_sel   = idx_q;
    assign cue_hit       = cue_hit_q;
    assign done_fric_all = dfa_q;
    assign shot_ready    = shot_ready_q;
    assign overrun       = overrun_q;
    assign ack_err       = ack_err_q;
endmodule
